in_service_8259a: RTL and testbench
===================================

Name: in_service_8259a

Overview:
In-Service Register (ISR) block of an 8259A-compatible programmable interrupt controller.
- Sets the ISR bit for the interrupt being acknowledged and clears bits on End-Of-Interrupt (EOI).
- Outputs the highest-priority in-service level as a one-hot vector, using the rotating priority scheme.
- Sits between the priority resolver/acknowledge control logic and the EOI command decoder.

Parameters:
- none: width is fixed at 8 interrupt levels (IR0..IR7).

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- priority_rotate  input  3  lowest-priority level, 0..7; 7 gives fixed priority IR0 highest
- interrupt  input  8  one-hot level being acknowledged; bit n = IRn
- start_in_service  input  1  qualifier: load `interrupt` into ISR this cycle
- end_of_interrupt  input  8  bit mask of ISR bits to clear this cycle
- in_service_register  output  8  registered ISR
- highest_level_in_service  output  8  registered one-hot highest-priority ISR bit; 0 if ISR empty

Behaviour:
- Reset, synchronous: in_service_register = 8'h00 and highest_level_in_service = 8'h00 on the first rising edge with reset=1. Reset overrides all other inputs, including mid-operation.
- ISR next state: next_isr = (isr & ~end_of_interrupt) | (start_in_service ? interrupt : 8'h00).
- The set term is applied after the clear term. Setting and clearing the same bit in the same cycle leaves the bit set.
- If `interrupt` has several bits set, all of them are set. No one-hot check is performed.
- start_in_service=0: `interrupt` is ignored.
- end_of_interrupt bits that are already 0 have no effect.
- Latency: ISR updates one clock after the inputs are sampled. The inputs are level-sampled each edge with no handshake. A pulse held for N cycles simply reapplies its operation N times.
- Priority order: highest priority is level (priority_rotate+1) mod 8, descending cyclically to priority_rotate as lowest.
  - priority_rotate=7: IR0 > IR1 > ... > IR7.
  - priority_rotate=3: IR4 > IR5 > IR6 > IR7 > IR0 > ... > IR3.
- Resolution algorithm, applied to next_isr:
  1. Rotate right by (priority_rotate+1) mod 8.
  2. Isolate the least-significant set bit (x & -x).
  3. Rotate left by the same amount.
- highest_level_in_service registers that resolved value. It is therefore always consistent with in_service_register in the same cycle: exactly one bit set when the ISR is non-zero, and 8'h00 when the ISR is zero.
- priority_rotate changes take effect on the next edge and may change the output while the ISR is unchanged.
- Rotate logic must be purely combinational, with no latches.

Optional Feature:
- Macro: ISR_SPECIAL_MASK_EN.
- Defined: adds two inputs:
  - special_mask_mode (1 bit)
  - interrupt_mask (8 bits)
- When special_mask_mode=1, resolution uses next_isr & ~interrupt_mask, so masked in-service levels do not block lower levels. The ISR contents themselves are unaffected by the mask.
- Not defined: these ports are absent and resolution uses next_isr unmasked.

Decomposition:
- Shared package pic_8259a_pkg contains:
  - constant NUM_IR_LEVELS = 8
  - typedef ir_vec_t (8-bit vector)
  - functions rotate_right(vec, amt), rotate_left(vec, amt) and isolate_lowest(vec); these are reused by the IRR priority resolver.
- One sub-module is natural: pic_priority_resolve. It is combinational: inputs vector + priority_rotate, output one-hot highest bit. It is shared with the interrupt-request resolver.

Test Plan:
- Reset: assert reset with start_in_service=1, interrupt=8'h01 -> ISR=8'h00, highest=8'h00.
- Fixed-priority fill (priority_rotate=7): pulse start_in_service with interrupt=8'h80, 8'h40, ... 8'h01 in turn -> ISR accumulates to 8'hFF.
  - highest is 8'h80, 8'h40, ..., 8'h01 after each step; each new bit outranks the previous one.
- EOI scan (priority_rotate=7): from ISR=8'hFF, apply end_of_interrupt=8'h01, 8'h02, ... 8'h80 -> ISR=8'hFE, 8'hFC, ..., 8'h00.
  - highest=8'h02, 8'h04, ..., 8'h80, then 8'h00.
- Rotated priority (priority_rotate=3): ISR=8'h99 -> highest=8'h10, since IR4 is top priority.
  - Clear bit 4 -> highest=8'h80.
  - Clear bit 7 -> highest=8'h01.
- Sweep priority_rotate 7..0 with full fill/EOI scans: with ISR=8'hFF, highest = 1 << ((priority_rotate+1) mod 8) for every rotation.
- Simultaneous events: ISR=8'h04; start_in_service=1, interrupt=8'h04, end_of_interrupt=8'h04 in the same cycle -> ISR stays 8'h04.
  - interrupt=8'h08 with end_of_interrupt=8'h04 -> ISR=8'h08.
  - start_in_service=0 with interrupt=8'h20 -> ISR unchanged.

Source files
------------

// File: rtl/pic_8259a_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pic_8259a_pkg
//  Purpose  : Shared types and bit-vector helpers for the 8259A-compatible
//             interrupt controller (ISR block and IRR priority resolver).
//  Contents : NUM_IR_LEVELS, ir_vec_t, rotate_right, rotate_left,
//             isolate_lowest
//  Revision : 1.0 - initial release
// ============================================================================
package pic_8259a_pkg;

  localparam int NUM_IR_LEVELS = 8;

  typedef logic [NUM_IR_LEVELS-1:0] ir_vec_t;

  // Cyclic right rotate. When amt is 0 the left-shift term shifts out every
  // bit, so the result is vec unchanged.
  function automatic ir_vec_t rotate_right(input ir_vec_t vec, input logic [2:0] amt);
    return (vec >> amt) | (vec << (4'd8 - {1'b0, amt}));
  endfunction

  // Cyclic left rotate (inverse of rotate_right for the same amount).
  function automatic ir_vec_t rotate_left(input ir_vec_t vec, input logic [2:0] amt);
    return (vec << amt) | (vec >> (4'd8 - {1'b0, amt}));
  endfunction

  // Keep only the least-significant set bit (x & -x); zero stays zero.
  function automatic ir_vec_t isolate_lowest(input ir_vec_t vec);
    return vec & (~vec + 8'd1);
  endfunction

endpackage : pic_8259a_pkg
`default_nettype wire

// File: rtl/pic_priority_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : pic_priority_resolve
//  Purpose  : Combinational rotating-priority resolver. Returns the one-hot
//             highest-priority set bit of i_vec. The highest-priority level
//             is (i_priority_rotate + 1) mod 8, descending cyclically down to
//             i_priority_rotate as lowest. Zero in gives zero out.
//  Ports    : i_vec             - candidate levels (bit n = IRn)
//             i_priority_rotate - lowest-priority level, 0..7
//             o_highest         - one-hot winner, or 0
//  Revision : 1.0 - initial release
// ============================================================================
module pic_priority_resolve
  import pic_8259a_pkg::*;
(
  input  ir_vec_t    i_vec,
  input  logic [2:0] i_priority_rotate,
  output ir_vec_t    o_highest
);

  // 3-bit add wraps naturally, giving (rotate + 1) mod 8.
  logic [2:0] w_amount;
  ir_vec_t    w_rotated;
  ir_vec_t    w_lowest;

  assign w_amount  = i_priority_rotate + 3'd1;
  // Rotating right moves the top-priority level to bit 0, so "highest
  // priority" becomes "least-significant set bit".
  assign w_rotated = rotate_right(i_vec, w_amount);
  assign w_lowest  = isolate_lowest(w_rotated);
  assign o_highest = rotate_left(w_lowest, w_amount);

endmodule : pic_priority_resolve
`default_nettype wire

// File: rtl/in_service_8259a.sv
`default_nettype none
// ============================================================================
//  Module   : in_service_8259a
//  Purpose  : In-Service Register of an 8259A-compatible PIC. Sets the ISR
//             bit(s) being acknowledged, clears bits on EOI, and registers
//             the highest-priority in-service level under rotating priority.
//  Ports    : clock                    - system clock, rising edge
//             reset                    - synchronous, active-high
//             priority_rotate          - lowest-priority level, 0..7
//             interrupt                - level(s) being acknowledged
//             start_in_service         - load interrupt into ISR this cycle
//             end_of_interrupt         - mask of ISR bits to clear
//             in_service_register      - registered ISR
//             highest_level_in_service - registered one-hot top ISR bit
//  Option   : ISR_SPECIAL_MASK_EN adds special_mask_mode and interrupt_mask;
//             in special mask mode masked in-service levels are excluded
//             from resolution (ISR contents are unaffected).
//  Revision : 1.0 - initial release
// ============================================================================
module in_service_8259a
  import pic_8259a_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] interrupt,
  input  logic       start_in_service,
  input  logic [7:0] end_of_interrupt,
`ifdef ISR_SPECIAL_MASK_EN
  input  logic       special_mask_mode,
  input  logic [7:0] interrupt_mask,
`endif
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service
);

  ir_vec_t r_isr;
  ir_vec_t r_highest;
  ir_vec_t w_next_isr;
  ir_vec_t w_resolve_in;
  ir_vec_t w_highest;

  // Clear first, then set: a bit both acknowledged and EOI'd stays set.
  assign w_next_isr = (r_isr & ~end_of_interrupt)
                    | (start_in_service ? interrupt : 8'h00);

`ifdef ISR_SPECIAL_MASK_EN
  assign w_resolve_in = special_mask_mode ? (w_next_isr & ~interrupt_mask)
                                          : w_next_isr;
`else
  assign w_resolve_in = w_next_isr;
`endif

  // Resolving next_isr (not r_isr) keeps both outputs in step each cycle.
  pic_priority_resolve u_resolve (
    .i_vec             (w_resolve_in),
    .i_priority_rotate (priority_rotate),
    .o_highest         (w_highest)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_isr     <= 8'h00;
      r_highest <= 8'h00;
    end else begin
      r_isr     <= w_next_isr;
      r_highest <= w_highest;
    end
  end

  assign in_service_register      = r_isr;
  assign highest_level_in_service = r_highest;

endmodule : in_service_8259a
`default_nettype wire

// File: tb/tb_in_service_8259a.sv
`default_nettype none
// ============================================================================
//  Module   : tb_in_service_8259a
//  Purpose  : Self-checking bench for in_service_8259a. A table of vectors
//             with hand-derived expectations, plus a rotation sweep and a
//             held-pulse sequence checked against a priority-walk model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_in_service_8259a;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] priority_rotate = 3'd7;
  logic [7:0] interrupt = 8'h00;
  logic       start_in_service = 1'b0;
  logic [7:0] end_of_interrupt = 8'h00;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
`ifdef ISR_SPECIAL_MASK_EN
  logic       special_mask_mode = 1'b0;
  logic [7:0] interrupt_mask = 8'h00;
`endif

  always #5 clock = ~clock;

  in_service_8259a dut (
    .clock                    (clock),
    .reset                    (reset),
    .priority_rotate          (priority_rotate),
    .interrupt                (interrupt),
    .start_in_service         (start_in_service),
    .end_of_interrupt         (end_of_interrupt),
`ifdef ISR_SPECIAL_MASK_EN
    .special_mask_mode        (special_mask_mode),
    .interrupt_mask           (interrupt_mask),
`endif
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service)
  );

  typedef struct {
    logic       rst;
    logic [2:0] rot;
    logic       start;
    logic [7:0] intr;
    logic [7:0] eoi;
    logic [7:0] exp_isr;
    logic [7:0] exp_hi;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] isr;
    logic [7:0] hi;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] isr_m = 8'h00;

  // Walk levels from highest to lowest priority; first in-service one wins.
  function automatic logic [7:0] model_hi(input logic [7:0] isr, input int rot);
    for (int k = 1; k <= 8; k++) begin
      int lvl;
      lvl = (rot + k) % 8;
      if (isr[lvl]) return 8'(1 << lvl);
    end
    return 8'h00;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic r, input logic [2:0] rot, input logic s,
                      input logic [7:0] in, input logic [7:0] e,
                      input logic [7:0] xi, input logic [7:0] xh, input string nm);
    exp_t ex;
    reset            = r;
    priority_rotate  = rot;
    start_in_service = s;
    interrupt        = in;
    end_of_interrupt = e;
    sb_q.push_back('{nm, xi, xh});
    @(posedge clock);
    #1;
    ex = sb_q.pop_front();
    total++;
    if (in_service_register !== ex.isr || highest_level_in_service !== ex.hi) begin
      bad++;
      $display("FAIL %s: isr=%h hi=%h expected isr=%h hi=%h",
               ex.name, in_service_register, highest_level_in_service, ex.isr, ex.hi);
    end
  endtask

  // Model-driven step: expectation comes from isr_m and model_hi.
  task automatic mstep(input logic r, input logic [2:0] rot, input logic s,
                       input logic [7:0] in, input logic [7:0] e, input string nm);
    logic [7:0] nx;
    nx = r ? 8'h00 : ((isr_m & ~e) | (s ? in : 8'h00));
    isr_m = nx;
    step(r, rot, s, in, e, nx, r ? 8'h00 : model_hi(nx, int'(rot)), nm);
  endtask

  vec_t tbl[$];

  initial begin
    // Reset overrides a concurrent acknowledge.
    tbl.push_back('{1'b1, 3'd7, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00});
    // Fixed-priority fill: each new lower-numbered bit outranks the last.
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h80, 8'h00, 8'h80, 8'h80});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h40, 8'h00, 8'hC0, 8'h40});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h20, 8'h00, 8'hE0, 8'h20});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h10, 8'h00, 8'hF0, 8'h10});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h08, 8'h00, 8'hF8, 8'h08});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h04, 8'h00, 8'hFC, 8'h04});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h02, 8'h00, 8'hFE, 8'h02});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h01, 8'h00, 8'hFF, 8'h01});
    // EOI scan upward.
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h01, 8'hFE, 8'h02});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h02, 8'hFC, 8'h04});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h04, 8'hF8, 8'h08});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h08, 8'hF0, 8'h10});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h10, 8'hE0, 8'h20});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h20, 8'hC0, 8'h40});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h40, 8'h80, 8'h80});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h00, 8'h80, 8'h00, 8'h00});
    // Rotated priority, rotate=3: IR4 is top.
    tbl.push_back('{1'b0, 3'd3, 1'b1, 8'h99, 8'h00, 8'h99, 8'h10});
    tbl.push_back('{1'b0, 3'd3, 1'b0, 8'h00, 8'h10, 8'h89, 8'h80});
    tbl.push_back('{1'b0, 3'd3, 1'b0, 8'h00, 8'h80, 8'h09, 8'h01});
    // Simultaneous set/clear and ignored interrupt.
    tbl.push_back('{1'b1, 3'd7, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h04, 8'h00, 8'h04, 8'h04});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h04, 8'h04, 8'h04, 8'h04});
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h08, 8'h04, 8'h08, 8'h08});
    tbl.push_back('{1'b0, 3'd7, 1'b0, 8'h20, 8'h00, 8'h08, 8'h08});
    // Multi-bit acknowledge sets every bit; EOI of a clear bit is a no-op.
    tbl.push_back('{1'b0, 3'd7, 1'b1, 8'h30, 8'h40, 8'h38, 8'h08});
    // Rotation change alone moves the output (rotate=4: IR5 top).
    tbl.push_back('{1'b0, 3'd4, 1'b0, 8'h00, 8'h00, 8'h38, 8'h20});
    // Reset mid-operation.
    tbl.push_back('{1'b1, 3'd4, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00});

    repeat (2) @(posedge clock);
    #1;
    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].rot, tbl[i].start, tbl[i].intr, tbl[i].eoi,
           tbl[i].exp_isr, tbl[i].exp_hi, $sformatf("vec%0d", i));

    // Rotation sweep: fill high-to-low, check the full-ISR winner, EOI scan.
    for (int r = 7; r >= 0; r--) begin
      mstep(1'b1, 3'(r), 1'b0, 8'h00, 8'h00, $sformatf("sweep_rst_r%0d", r));
      for (int b = 7; b >= 0; b--)
        mstep(1'b0, 3'(r), 1'b1, 8'(1 << b), 8'h00, $sformatf("sweep_fill_r%0d_b%0d", r, b));
      total++;
      if (highest_level_in_service !== 8'(1 << ((r + 1) % 8))) begin
        bad++;
        $display("FAIL full_isr_winner_r%0d: hi=%h expected %h", r,
                 highest_level_in_service, 8'(1 << ((r + 1) % 8)));
      end
      for (int b = 0; b < 8; b++)
        mstep(1'b0, 3'(r), 1'b0, 8'h00, 8'(1 << b), $sformatf("sweep_eoi_r%0d_b%0d", r, b));
    end

    // Held acknowledge reapplies harmlessly; held EOI with random rotations.
    mstep(1'b1, 3'd7, 1'b0, 8'h00, 8'h00, "hold_rst");
    repeat (3) mstep(1'b0, 3'd2, 1'b1, 8'h42, 8'h00, "hold_ack");
    repeat (2) mstep(1'b0, 3'd5, 1'b0, 8'h00, 8'h02, "hold_eoi");
    for (int n = 0; n < 24; n++)
      mstep(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            $sformatf("rand%0d", n));

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: left=%0d expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_in_service_8259a
`default_nettype wire
